// File: rtl/dbus_pkg.sv
// Shared address map and register field positions for the data bus responder.
package dbus_pkg;
    localparam logic [31:0] RAM_BASE   = 32'h0000_0000;
    localparam logic [31:0] GPIO_OUT_A = 32'h0000_1000;
    localparam logic [31:0] GPIO_IN_A  = 32'h0000_1004;
    localparam logic [31:0] CYCLE_A    = 32'h0000_1008;
    localparam logic [31:0] TCMP_A     = 32'h0000_100C;
    localparam logic [31:0] TSTAT_A    = 32'h0000_1010;
    localparam logic [31:0] ERRCLR_A   = 32'h0000_1014;

    localparam int TSTAT_FLAG = 0;
    localparam int TSTAT_EN   = 1;
endpackage

// File: rtl/dbus_timer.sv
// Free-running cycle counter plus compare timer with sticky match flag and masked irq.
module dbus_timer
    import dbus_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cycle_we,
    input  logic        tcmp_we,
    input  logic        tstat_we,
    input  logic [31:0] wdata,
    output logic [31:0] cycle,
    output logic [31:0] tcmp,
    output logic        enable,
    output logic        flag,
    output logic        irq
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle  <= '0;
            tcmp   <= '0;
            enable <= 1'b0;
            flag   <= 1'b0;
        end else begin
            cycle <= cycle_we ? wdata : cycle + 32'd1;
            if (tcmp_we)
                tcmp <= wdata;
            if (tstat_we)
                enable <= wdata[TSTAT_EN];
            // A match in the same cycle as a W1C keeps the flag set.
            if (enable && (cycle == tcmp))
                flag <= 1'b1;
            else if (tstat_we && wdata[TSTAT_FLAG])
                flag <= 1'b0;
        end
    end

    assign irq = flag & enable;
endmodule

// File: rtl/data_bus_responder.sv
// MEM-stage responder: data RAM, GPIO, cycle counter/timer and sticky bus error.
module data_bus_responder
    import dbus_pkg::*;
#(
    parameter int RAM_WORDS = 64,
    parameter int GPIO_W    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       bAddr,
    input  logic [31:0]       bWData,
    input  logic              MemRead,
    input  logic              MemWrite,
    output logic [31:0]       bRData,
    output logic [GPIO_W-1:0] gpio_out,
    input  logic [GPIO_W-1:0] gpio_in,
    output logic              irq,
    output logic              bus_err
);
    localparam int AW = $clog2(RAM_WORDS);

    logic [31:0]       ram [RAM_WORDS];
    logic [31:0]       ram_off;
    logic              ram_hit, hit_gout, hit_gin, hit_cyc, hit_tcmp, hit_tstat, hit_eclr;
    logic              mapped;
    logic [GPIO_W-1:0] gin_s1, gin_s2;
    logic [31:0]       cycle, tcmp;
    logic              enable, flag;

    // Offset compare also rejects addresses below the base via wraparound.
    assign ram_off   = bAddr - RAM_BASE;
    assign ram_hit   = ram_off < 32'(RAM_WORDS * 4);
    assign hit_gout  = bAddr[31:2] == GPIO_OUT_A[31:2];
    assign hit_gin   = bAddr[31:2] == GPIO_IN_A[31:2];
    assign hit_cyc   = bAddr[31:2] == CYCLE_A[31:2];
    assign hit_tcmp  = bAddr[31:2] == TCMP_A[31:2];
    assign hit_tstat = bAddr[31:2] == TSTAT_A[31:2];
    assign hit_eclr  = bAddr[31:2] == ERRCLR_A[31:2];
    assign mapped    = ram_hit | hit_gout | hit_gin | hit_cyc | hit_tcmp | hit_tstat | hit_eclr;

    always_ff @(posedge clk) begin
        if (MemWrite && ram_hit)
            ram[ram_off[AW+1:2]] <= bWData;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gpio_out <= '0;
            gin_s1   <= '0;
            gin_s2   <= '0;
            bus_err  <= 1'b0;
        end else begin
            gin_s1 <= gpio_in;
            gin_s2 <= gin_s1;
            if (MemWrite && hit_gout)
                gpio_out <= bWData[GPIO_W-1:0];
            if (MemWrite && hit_eclr)
                bus_err <= 1'b0;
            else if ((MemRead || MemWrite) && !mapped)
                bus_err <= 1'b1;
        end
    end

    dbus_timer u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .cycle_we (MemWrite & hit_cyc),
        .tcmp_we  (MemWrite & hit_tcmp),
        .tstat_we (MemWrite & hit_tstat),
        .wdata    (bWData),
        .cycle    (cycle),
        .tcmp     (tcmp),
        .enable   (enable),
        .flag     (flag),
        .irq      (irq)
    );

    always_comb begin
        bRData = '0;
        if (MemRead) begin
            if (ram_hit)
                bRData = ram[ram_off[AW+1:2]];
            else if (hit_gout)
                bRData[GPIO_W-1:0] = gpio_out;
            else if (hit_gin)
                bRData[GPIO_W-1:0] = gin_s2;
            else if (hit_cyc)
                bRData = cycle;
            else if (hit_tcmp)
                bRData = tcmp;
            else if (hit_tstat) begin
                bRData[TSTAT_FLAG] = flag;
                bRData[TSTAT_EN]   = enable;
            end
        end
    end
endmodule

// File: tb/tb_data_bus_responder.sv
// Directed bench: vector table for bus accesses plus hand sequences for timing corners.
module tb_data_bus_responder;
    import dbus_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] bAddr, bWData, bRData;
    logic        MemRead, MemWrite;
    logic [7:0]  gpio_out, gpio_in;
    logic        irq, bus_err;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        chk;
        logic [31:0] exp;
    } vec_t;

    vec_t vt[$];

    data_bus_responder #(.RAM_WORDS(64), .GPIO_W(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bAddr    (bAddr),
        .bWData   (bWData),
        .MemRead  (MemRead),
        .MemWrite (MemWrite),
        .bRData   (bRData),
        .gpio_out (gpio_out),
        .gpio_in  (gpio_in),
        .irq      (irq),
        .bus_err  (bus_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One bus cycle: drive at the falling edge, settle, leave held across the next rising edge.
    task automatic cyc(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        MemRead  = rd;
        MemWrite = wr;
        bAddr    = a;
        bWData   = d;
        #1;
    endtask

    initial begin
        logic found;
        rst_n = 1'b0; MemRead = 0; MemWrite = 0; bAddr = 0; bWData = 0; gpio_in = 8'h00;

        vt.push_back('{0, 1, 32'h40,      32'hDEAD_BEEF, 0, 32'h0});
        vt.push_back('{1, 0, 32'h40,      32'h0,         1, 32'hDEAD_BEEF});
        vt.push_back('{1, 0, 32'h43,      32'h0,         1, 32'hDEAD_BEEF});
        vt.push_back('{0, 1, 32'h44,      32'h1234_5678, 0, 32'h0});
        vt.push_back('{1, 0, 32'h44,      32'h0,         1, 32'h1234_5678});
        vt.push_back('{1, 1, 32'h40,      32'h1111_1111, 1, 32'hDEAD_BEEF});
        vt.push_back('{1, 0, 32'h40,      32'h0,         1, 32'h1111_1111});
        vt.push_back('{0, 0, 32'h40,      32'h0,         1, 32'h0});
        vt.push_back('{0, 1, 32'h0,       32'hCAFE_0000, 0, 32'h0});
        vt.push_back('{0, 1, 32'h100,     32'h5555_5555, 0, 32'h0});
        vt.push_back('{1, 0, 32'h0,       32'h0,         1, 32'hCAFE_0000});
        vt.push_back('{0, 1, GPIO_OUT_A,  32'hFFFF_FFA5, 0, 32'h0});
        vt.push_back('{1, 0, GPIO_OUT_A,  32'h0,         1, 32'h0000_00A5});
        vt.push_back('{0, 1, TCMP_A,      32'h55,        0, 32'h0});
        vt.push_back('{1, 0, TCMP_A,      32'h0,         1, 32'h55});
        vt.push_back('{1, 0, TSTAT_A,     32'h0,         1, 32'h0});
        vt.push_back('{1, 0, ERRCLR_A,    32'h0,         1, 32'h0});
        vt.push_back('{0, 1, GPIO_IN_A,   32'hFF,        0, 32'h0});
        vt.push_back('{1, 0, GPIO_IN_A,   32'h0,         1, 32'h0});
        vt.push_back('{1, 0, 32'h100,     32'h0,         1, 32'h0});
        vt.push_back('{1, 0, 32'h2000,    32'h0,         1, 32'h0});

        // Reset state, then CYCLE reads n in the n-th cycle after release.
        repeat (2) @(negedge clk);
        #1;
        chk("rst_gpio_out", 32'(gpio_out), 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        chk("rst_bus_err", 32'(bus_err), 32'h0);
        @(negedge clk);
        MemRead = 1; bAddr = CYCLE_A; rst_n = 1'b1;
        #1 chk("cycle_after_rst_0", bRData, 32'd0);
        for (int n = 1; n <= 3; n++) begin
            cyc(1, 0, CYCLE_A, 0);
            chk($sformatf("cycle_after_rst_%0d", n), bRData, 32'(n));
        end

        foreach (vt[i]) begin
            cyc(vt[i].rd, vt[i].wr, vt[i].addr, vt[i].wdata);
            if (vt[i].chk)
                chk($sformatf("vec%0d_rdata", i), bRData, vt[i].exp);
        end
        chk("gpio_out_pin", 32'(gpio_out), 32'hA5);

        // Sticky bus error, ERRCLR, and the read-only GPIO_IN write exemption.
        cyc(0, 0, 0, 0);
        chk("err_set_by_unmapped_read", 32'(bus_err), 32'h1);
        cyc(0, 1, ERRCLR_A, 32'h1234);
        cyc(0, 1, GPIO_IN_A, 32'h1);
        chk("err_cleared", 32'(bus_err), 32'h0);
        cyc(0, 1, 32'h2000, 32'h1);
        chk("err_not_set_by_gpio_in_wr", 32'(bus_err), 32'h0);
        cyc(0, 0, 0, 0);
        chk("err_set_by_unmapped_write", 32'(bus_err), 32'h1);

        // CYCLE write beats the increment, then wraps.
        cyc(0, 1, CYCLE_A, 32'hFFFF_FFFE);
        cyc(1, 0, CYCLE_A, 0);
        chk("cycle_load", bRData, 32'hFFFF_FFFE);
        cyc(1, 0, CYCLE_A, 0);
        chk("cycle_inc", bRData, 32'hFFFF_FFFF);
        cyc(1, 0, CYCLE_A, 0);
        chk("cycle_wrap", bRData, 32'h0);

        // GPIO input synchronizer: two edges before the new value is visible.
        @(negedge clk);
        gpio_in = 8'h3C; MemRead = 1; MemWrite = 0; bAddr = GPIO_IN_A;
        #1 chk("gpio_in_0_edges", bRData, 32'h0);
        cyc(1, 0, GPIO_IN_A, 0);
        chk("gpio_in_1_edge", bRData, 32'h0);
        cyc(1, 0, GPIO_IN_A, 0);
        chk("gpio_in_2_edges", bRData, 32'h3C);

        // Timer compare: irq rises one edge after CYCLE reads 20.
        cyc(0, 1, CYCLE_A, 0);
        cyc(0, 1, TCMP_A, 32'd20);
        cyc(0, 1, TSTAT_A, 32'h2);
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            cyc(1, 0, CYCLE_A, 0);
            if (bRData == 32'd20) begin
                found = 1'b1;
                chk("irq_at_match", 32'(irq), 32'h0);
                cyc(1, 0, TSTAT_A, 0);
                chk("irq_after_match", 32'(irq), 32'h1);
                chk("tstat_after_match", bRData, 32'h3);
            end
        end
        chk("timer_reached_match", 32'(found), 32'h1);
        cyc(0, 1, TSTAT_A, 32'h3);
        cyc(1, 0, TSTAT_A, 0);
        chk("w1c_irq", 32'(irq), 32'h0);
        chk("w1c_tstat", bRData, 32'h2);

        // Match and W1C in the same cycle: the set wins.
        cyc(0, 1, CYCLE_A, 32'd19);
        cyc(0, 0, 0, 0);
        cyc(0, 1, TSTAT_A, 32'h3);
        cyc(1, 0, TSTAT_A, 0);
        chk("set_wins_tstat", bRData, 32'h3);
        chk("set_wins_irq", 32'(irq), 32'h1);

        // Disabling masks irq but keeps the flag.
        cyc(0, 1, TSTAT_A, 32'h0);
        cyc(1, 0, TSTAT_A, 0);
        chk("mask_tstat", bRData, 32'h1);
        chk("mask_irq", 32'(irq), 32'h0);
        cyc(0, 1, TSTAT_A, 32'h2);
        cyc(1, 0, TSTAT_A, 0);
        chk("unmask_irq", 32'(irq), 32'h1);

        // Asynchronous mid-run reset with a write in flight.
        cyc(0, 1, GPIO_OUT_A, 32'h5A);
        #3 rst_n = 1'b0;
        #1;
        chk("midrst_gpio_out", 32'(gpio_out), 32'h0);
        chk("midrst_irq", 32'(irq), 32'h0);
        chk("midrst_bus_err", 32'(bus_err), 32'h0);
        @(negedge clk);
        MemWrite = 0; MemRead = 0;
        rst_n = 1'b1;
        cyc(1, 0, GPIO_IN_A, 0);
        chk("midrst_sync_flushed", bRData, 32'h0);
        cyc(1, 0, TCMP_A, 0);
        chk("midrst_tcmp", bRData, 32'h0);
        cyc(1, 0, TSTAT_A, 0);
        chk("midrst_tstat", bRData, 32'h0);
        cyc(1, 0, GPIO_OUT_A, 0);
        chk("midrst_gpio_rd", bRData, 32'h0);
        cyc(0, 1, 32'h40, 32'h0000_0077);
        cyc(1, 0, 32'h40, 0);
        chk("ram_write_after_rst", bRData, 32'h77);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
